// File: rtl/lfsr_range_rng.sv
// ---------------------------------------------------------------------------
// lfsr_range_rng
// Dual Galois-LFSR random source with a ranged draw engine for game logic.
// LFSR A steps every cycle; LFSR B steps once every STEP_B_DIV cycles. Their
// XOR is the raw random word. A request draws a value uniformly in
// [0, range_max] by masking the raw word and rejecting out-of-range results;
// after MAX_TRIES rejections it falls back to the halved candidate.
//
// Ports
//   slow_clk1  in   clock
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load both LFSRs from seed_in (wins over step/entropy)
//   seed_in    in   WIDTH seed value (B takes its complement)
//   ent_pulse  in   entropy strobe, mixes the free-running counter into A
//   req        in   request one ranged value (ignored while busy)
//   range_max  in   WIDTH inclusive upper bound, captured on acceptance
//   busy       out  draw in progress
//   rnd_valid  out  one-cycle strobe, rnd_out holds a new value
//   rnd_out    out  WIDTH ranged result, held until the next result
//   raw        out  WIDTH combinational A ^ B
// ---------------------------------------------------------------------------
module lfsr_range_rng #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS_A     = 'hB8,
    parameter logic [WIDTH-1:0] TAPS_B     = 'h8E,
    parameter logic [WIDTH-1:0] SEED_A     = 'h01,
    parameter logic [WIDTH-1:0] SEED_B     = 'hA5,
    parameter int               STEP_B_DIV = 3,
    parameter int               MAX_TRIES  = 4
) (
    input  logic             slow_clk1,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             ent_pulse,
    input  logic             req,
    input  logic [WIDTH-1:0] range_max,
    output logic             busy,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_out,
    output logic [WIDTH-1:0] raw
);

    localparam int DIV_W = (STEP_B_DIV > 1) ? $clog2(STEP_B_DIV) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_B_DIV - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DRAW = 1'b1;

    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] taps);
        return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
    endfunction

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [DIV_W-1:0] r_div_cnt;
    logic [WIDTH-1:0] r_ent_cnt;
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_range;
    logic [TRY_W-1:0] r_tries;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;

    logic [WIDTH-1:0] w_a_step;
    logic [WIDTH-1:0] w_a_ent;
    logic [WIDTH-1:0] w_seed_inv;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [DIV_W-1:0] w_div_next;
    logic [WIDTH-1:0] w_shift [WIDTH];
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_cand;

    assign raw       = r_a ^ r_b;
    assign busy      = r_busy;
    assign rnd_valid = r_valid;
    assign rnd_out   = r_out;

    // OR of every right shift of range_r sets all bits below its MSB, which is
    // the smallest all-ones mask covering range_r (0 stays 0).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            assign w_shift[gi] = r_range >> gi;
        end
    endgenerate

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask = w_mask | w_shift[i];
        end
    end

    // Candidate uses the register values before this cycle's step.
    assign w_cand = raw & w_mask;

    // LFSR next-state: seed load overrides stepping and entropy. Zero
    // substitution keeps both LFSRs out of the all-zero lock-up state.
    always_comb begin
        w_a_step   = galois_step(r_a, TAPS_A);
        w_a_ent    = w_a_step ^ r_ent_cnt;
        w_seed_inv = ~seed_in;
        w_a_next   = w_a_step;
        w_b_next   = r_b;
        w_div_next = r_div_cnt + 1'b1;
        if (seed_load) begin
            w_a_next   = (seed_in == '0) ? SEED_A : seed_in;
            w_b_next   = (w_seed_inv == '0) ? SEED_B : w_seed_inv;
            w_div_next = '0;
        end else begin
            if (ent_pulse) begin
                w_a_next = (w_a_ent == '0) ? SEED_A : w_a_ent;
            end
            if (r_div_cnt == DIV_LAST) begin
                w_b_next   = galois_step(r_b, TAPS_B);
                w_div_next = '0;
            end
        end
    end

    always_ff @(posedge slow_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= SEED_A;
            r_b       <= SEED_B;
            r_div_cnt <= '0;
            r_ent_cnt <= '0;
            r_state   <= S_IDLE;
            r_range   <= '0;
            r_tries   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_out     <= '0;
        end else begin
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_div_cnt <= w_div_next;
            r_ent_cnt <= r_ent_cnt + 1'b1;
            r_valid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (range_max == '0) begin
                            // Only one possible answer: return it without drawing.
                            r_out   <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_range <= range_max;
                            r_tries <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DRAW;
                        end
                    end
                end
                S_DRAW: begin
                    if (w_cand <= r_range) begin
                        r_out   <= w_cand;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_tries == TRY_LAST) begin
                        // mask < 2*range_r, so halving any candidate lands in range.
                        r_out   <= w_cand >> 1;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tries <= r_tries + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// ---------------------------------------------------------------------------
// tb_lfsr_range_rng
// Directed bench for lfsr_range_rng. A default instance covers LFSR sequences,
// seeding, entropy and ranged draws; a MAX_TRIES=1 instance sharing the LFSR
// inputs covers the fallback path. A small reference model of the two LFSRs
// supplies the raw word used to predict each draw.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfsr_range_rng;

    logic       slow_clk1;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       ent_pulse;
    logic       req;
    logic [7:0] range_max;
    logic       busy;
    logic       rnd_valid;
    logic [7:0] rnd_out;
    logic [7:0] raw;

    logic       req_f;
    logic [7:0] range_f;
    logic       busy_f;
    logic       rnd_valid_f;
    logic [7:0] rnd_out_f;
    logic [7:0] raw_f;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_range_rng u_dut (
        .slow_clk1 (slow_clk1),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .ent_pulse (ent_pulse),
        .req       (req),
        .range_max (range_max),
        .busy      (busy),
        .rnd_valid (rnd_valid),
        .rnd_out   (rnd_out),
        .raw       (raw)
    );

    lfsr_range_rng #(.MAX_TRIES(1)) u_dut_f (
        .slow_clk1 (slow_clk1),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .ent_pulse (ent_pulse),
        .req       (req_f),
        .range_max (range_f),
        .busy      (busy_f),
        .rnd_valid (rnd_valid_f),
        .rnd_out   (rnd_out_f),
        .raw       (raw_f)
    );

    initial slow_clk1 = 1'b0;
    always #5 slow_clk1 = ~slow_clk1;

    // Reference model of the two LFSRs, divider and entropy counter.
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_ent;
    int         m_div;
    logic [7:0] model_raw;
    assign model_raw = m_a ^ m_b;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] t);
        return x[0] ? ((x >> 1) ^ t) : (x >> 1);
    endfunction

    function automatic logic [7:0] mask_of(input logic [7:0] r);
        int m;
        m = 0;
        while (m < int'(r)) m = (m << 1) | 1;
        return 8'(m);
    endfunction

    always @(posedge slow_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            m_a   <= 8'h01;
            m_b   <= 8'hA5;
            m_div <= 0;
            m_ent <= 8'h00;
        end else begin
            logic [7:0] a_s;
            logic [7:0] a_e;
            logic [7:0] s_inv;
            a_s   = lfsr_next(m_a, 8'hB8);
            a_e   = a_s ^ m_ent;
            s_inv = ~seed_in;
            m_ent <= m_ent + 8'd1;
            if (seed_load) begin
                m_a   <= (seed_in == 8'h00) ? 8'h01 : seed_in;
                m_b   <= (s_inv == 8'h00) ? 8'hA5 : s_inv;
                m_div <= 0;
            end else begin
                if (ent_pulse) m_a <= (a_e == 8'h00) ? 8'h01 : a_e;
                else           m_a <= a_s;
                if (m_div == 2) begin
                    m_b   <= lfsr_next(m_b, 8'h8E);
                    m_div <= 0;
                end else begin
                    m_div <= m_div + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Starts and ends on a negedge; leaves rnd_valid high unless hold is set.
    task automatic draw(input logic [7:0] rmax, input bit hold);
        logic [7:0] m;
        logic [7:0] cand;
        logic [7:0] expv;
        bit         fin;
        m = mask_of(rmax);
        req = 1'b1;
        range_max = rmax;
        @(negedge slow_clk1);
        if (rmax == 8'h00) begin
            req = 1'b0;
            check("zero_valid", rnd_valid, 1);
            check("zero_out", rnd_out, 0);
            check("zero_busy", busy, 0);
            return;
        end
        if (!hold) req = 1'b0;
        range_max = ~rmax;
        check("busy_set", busy, 1);
        check("no_early_valid", rnd_valid, 0);
        fin = 1'b0;
        expv = 8'h00;
        for (int t = 0; t < 4 && !fin; t++) begin
            cand = model_raw & m;
            if (cand <= rmax) begin
                expv = cand;
                fin = 1'b1;
            end else if (t == 3) begin
                expv = cand >> 1;
                fin = 1'b1;
            end
            @(negedge slow_clk1);
            if (fin) begin
                check("draw_valid", rnd_valid, 1);
                check("draw_out", rnd_out, expv);
                check("draw_busy_clr", busy, 0);
            end else begin
                check("draw_pending", rnd_valid, 0);
            end
        end
        req = 1'b0;
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge slow_clk1);
                check("no_extra_valid", rnd_valid, 0);
            end
        end
    endtask

    task automatic draw_f(input logic [7:0] rmax);
        logic [7:0] cand;
        logic [7:0] expv;
        req_f = 1'b1;
        range_f = rmax;
        @(negedge slow_clk1);
        req_f = 1'b0;
        check("f_busy", busy_f, 1);
        cand = model_raw & mask_of(rmax);
        expv = (cand <= rmax) ? cand : (cand >> 1);
        @(negedge slow_clk1);
        check("f_valid", rnd_valid_f, 1);
        check("f_out", rnd_out_f, expv);
        check("f_bound", rnd_out_f <= rmax, 1);
    endtask

    logic [7:0] seq_tbl [6];
    int         hist [6];
    int         edges;

    initial begin
        seq_tbl[0] = 8'h1D; seq_tbl[1] = 8'hF9; seq_tbl[2] = 8'hF2;
        seq_tbl[3] = 8'hCB; seq_tbl[4] = 8'h6F; seq_tbl[5] = 8'h8F;
        for (int i = 0; i < 6; i++) hist[i] = 0;

        rst_n = 1'b0; seed_load = 1'b0; seed_in = 8'h00; ent_pulse = 1'b0;
        req = 1'b0; range_max = 8'h00; req_f = 1'b0; range_f = 8'h00;
        repeat (3) @(negedge slow_clk1);
        check("rst_raw", raw, 8'hA4);
        check("rst_busy", busy, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_out", rnd_out, 0);
        check("rst_out_f", rnd_out_f, 0);
        rst_n = 1'b1;

        // Hand-derived raw words: A runs 01,B8,5C,2E,17,B3,E1; B steps on edges 3,6.
        for (int k = 0; k < 6; k++) begin
            @(negedge slow_clk1);
            check($sformatf("seq_raw%0d", k), raw, seq_tbl[k]);
        end

        // Joint period: A 255, B 765 cycles.
        edges = 6;
        while (edges < 765) begin
            @(negedge slow_clk1);
            edges++;
            check("period_raw", raw, model_raw);
            if (edges == 255) check("not_back_at_255", raw == 8'hA4, 0);
        end
        check("period_765", raw, 8'hA4);

        seed_load = 1'b1; seed_in = 8'h00;
        @(negedge slow_clk1);
        seed_load = 1'b0;
        check("seed00_raw", raw, 8'hFE);
        seed_load = 1'b1; seed_in = 8'hFF;
        @(negedge slow_clk1);
        seed_load = 1'b0;
        check("seedFF_raw", raw, 8'h5A);
        seed_load = 1'b1; seed_in = 8'h3C; ent_pulse = 1'b1;
        @(negedge slow_clk1);
        seed_load = 1'b0;
        check("seed_beats_ent", raw, 8'hFF);

        for (int k = 0; k < 300; k++) begin
            @(negedge slow_clk1);
            check("ent_raw", raw, model_raw);
        end
        ent_pulse = 1'b0;

        draw(8'h00, 1'b0);
        for (int k = 0; k < 600; k++) begin
            draw(8'd5, 1'b0);
            check("range5_bound", rnd_out <= 8'd5, 1);
            if (rnd_out <= 8'd5) hist[rnd_out]++;
        end
        for (int v = 0; v < 6; v++) check($sformatf("hist%0d", v), hist[v] >= 40, 1);

        draw(8'd200, 1'b1);
        draw(8'd37, 1'b0);
        draw(8'd1, 1'b0);
        draw(8'h00, 1'b0);
        draw(8'hFF, 1'b0);

        for (int k = 0; k < 40; k++) draw_f(8'd4);

        // Asynchronous reset during a draw.
        req = 1'b1; range_max = 8'd100;
        @(negedge slow_clk1);
        req = 1'b0;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rnd_valid, 0);
        check("mid_rst_out", rnd_out, 0);
        check("mid_rst_raw", raw, 8'hA4);
        @(negedge slow_clk1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge slow_clk1);
            check("post_rst_valid", rnd_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
